// File: rtl/instr_queue.sv
// Instruction queue for the RISC_16 manual-test top: keyed-in switch words are stored in a FIFO and fed on fetch.
// Define INSTR_QUEUE_DEBOUNCE_EN to insert the load-key debouncer between the synchronizer and the edge detector.
module instr_queue #(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_load_n,
    input  logic [9:0]               sw,
    input  logic                     run,
    input  logic [4:0]               tick,
    output logic [15:0]              instruction,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     done
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned LW         = AW + 1;
    localparam logic [4:0]  TICK_FETCH = 5'b10000;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       key_sync;
    logic             key_clean;
    logic             key_prev;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             drop;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic [15:0]      mem [DEPTH];

    // Two-flop synchronizer; idles at the released level.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync <= 2'b11;
        end else begin
            key_sync <= {key_sync[0], key_load_n};
        end
    end

`ifdef INSTR_QUEUE_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] db_cnt;
    logic          key_db;

    // Accept a new key level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_db <= 1'b1;
            db_cnt <= '0;
        end else if (key_sync[1] == key_db) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            key_db <= key_sync[1];
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

    assign key_clean = key_db;
`else
    assign key_clean = key_sync[1];

    // DEBOUNCE_CYCLES has no effect without the debouncer.
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev <= 1'b1;
        end else begin
            key_prev <= key_clean;
        end
    end

    // Falling edge of the cleaned key is a press; release is ignored.
    assign push  = key_prev & ~key_clean;
    assign pop   = run & (tick == TICK_FETCH) & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        level_nxt = level;
        case ({wr_en, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is left uncleared by reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {sw[9:6], sw[5:2], 6'b000000, sw[1:0]};
        end
    end

    assign instruction = empty ? 16'h0000 : mem[rd_ptr];
    assign instr_valid = ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == S_DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (run) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_nxt = S_LOAD;
                end else if (pop && (level_nxt == '0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!run) begin
                    state_nxt = S_LOAD;
                end else if (wr_en) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

Upstream instruction feeder for the RISC_16 manual-test top. Captures instructions keyed in on the slide switches, one per debounced press of the load button, into a DEPTH-entry FIFO. In run mode it presents the head word to the processor and retires it on each fetch phase (tick == 5'b10000). Replaces the direct switch-to-instruction path, so a short program can be entered first and then executed back-to-back.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..16.
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a key level change; only used with debounce compiled in.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- key_load_n  in  1  raw load pushbutton, active-low, asynchronous to clk.
- sw  in  10  switch word, encoded to {sw[9:6], sw[5:2], 6'b0, sw[1:0]}.
- run  in  1  level: 1 = feed the processor, 0 = load-only.
- tick  in  5  processor phase, one-hot; 5'b10000 = fetch.
- instruction  out  16  head word; 16'h0000 (NOP) when empty.
- instr_valid  out  1  queue non-empty.
- level  out  $clog2(DEPTH)+1  stored entry count, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a push was dropped.
- done  out  1  high in DONE state.

## Operation
- Input path: key_load_n passes through a 2-FF synchronizer, then the debouncer, then a falling-edge detector, giving a one-cycle push pulse per press. Release produces no pulse.
- Push: on push pulse, write the encoded sw word at wr_ptr. wr_ptr increments mod DEPTH and level increments. sw is sampled in the pulse cycle.
- Pop: pop = run & (tick == 5'b10000) & !empty. rd_ptr increments mod DEPTH and level decrements. The processor latches instruction on that same edge.
- instruction = empty ? 16'h0000 : mem[rd_ptr]. This is combinational from registered pointers and storage.
- Simultaneous push and pop: both pointers advance and level is unchanged. This holds even when full, where the push is accepted.
- Push while full with no pop: word dropped, pointers and level unchanged, overflow set to 1. Only reset clears overflow.
- Pop while empty: cannot occur. instruction stays 16'h0000.
- Non-one-hot tick values never pop.
- FSM, three states:
  - LOAD: reset state. Go to RUN when run=1.
  - RUN: go to DONE when level reaches 0 through a pop. Go to LOAD when run=0.
  - DONE: go to LOAD when run=0. A push in DONE goes back to RUN.
- run=1 with an empty queue in LOAD goes to RUN. It reaches DONE only after a pop empties the queue.
- done = (state == DONE).
- Reset mid-operation: pointers and level return to 0 and state to LOAD. The partially entered program is discarded. Storage contents need not be cleared.

## Timing
- Reset values:
  - instruction 16'h0000, instr_valid 0, level 0, full 0, empty 1, overflow 0, done 0.
  - Debounced key state = released (1), debounce counter 0, state LOAD.
- Synchronizer latency: 2 cycles.
- Debounced level changes after DEBOUNCE_CYCLES consecutive equal synchronized samples. Any bounce restarts the count.
- Push pulse is 1 cycle after the debounced fall.
- level, full, empty and instruction update at the edge ending the push/pop cycle.
- A word pushed into an empty queue appears on instruction the next cycle.
- Back-to-back pops are limited only by tick: one per processor instruction.

## Configuration
- INSTR_QUEUE_DEBOUNCE_EN defined: debouncer instantiated as above.
- Not defined: synchronizer output feeds the edge detector directly. Push occurs exactly 3 cycles after key_load_n falls. DEBOUNCE_CYCLES is ignored.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then press with sw=10'b0001_0010_11 (debounce on, DEBOUNCE_CYCLES=16) -> exactly one push; instruction=16'h1203, level=1, instr_valid=1.
- Press with 5 bounces of 3 cycles each, then hold low 40 cycles -> exactly one push; release bounce -> no push.
- Push 9 words, DEPTH=8, run=0 -> level=8, full=1, overflow=1; 9th word absent; head = 1st word.
- Load 3 words, run=1, cycle tick through the 5 one-hot phases -> instruction advances only after each 5'b10000 edge; after 3rd fetch empty=1, done=1, instruction=16'h0000.
- Full queue, push pulse in a fetch cycle with run=1 -> level stays 8, overflow stays 0, pushed word is last out.
- Reset asserted in RUN with level=5 -> next cycle level=0, empty=1, done=0, state LOAD; overflow cleared.
